// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared types and defaults for the multi-channel PWM generator.
//   pwm_state_e : period-counter FSM states (idle, counting up, counting down)
//   pwm_mode_e  : alignment mode of the whole generator (edge or center)
// -----------------------------------------------------------------------------
package pwm_pkg;

  // Default geometry used by the top level and the per-channel comparator.
  localparam int PWM_DEFAULT_WIDTH = 16;
  localparam int PWM_DEFAULT_N     = 4;

  typedef enum logic [1:0] {
    PWM_IDLE = 2'd0,
    PWM_UP   = 2'd1,
    PWM_DOWN = 2'd2
  } pwm_state_e;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

endpackage

// File: rtl/pwm_channel_cmp.sv
// -----------------------------------------------------------------------------
// pwm_channel_cmp
// One PWM channel: holds the channel's active (shadow) duty and polarity,
// clamps the duty to the active period, compares it against the shared
// counter and registers the resulting output.
//
// All compare inputs are the *next-cycle* values coming from the top level
// (counter, period, mode, idle flag). Evaluating them one cycle early lets the
// output flop line up with the counter value of the cycle in which it is seen.
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   load      in   1 = capture duty_in/pol_in on this edge (idle or boundary)
//   idle_d    in   1 = generator will be idle next cycle
//   mode_d    in   alignment mode in effect next cycle
//   cnt_d     in   counter value of the next cycle
//   period_d  in   active period of the next cycle
//   duty_in   in   requested duty for this channel
//   pol_in    in   requested polarity (1 = inverted output)
//   pwm_out   out  registered PWM output
// -----------------------------------------------------------------------------
module pwm_channel_cmp
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             idle_d,
  input  pwm_mode_e        mode_d,
  input  logic [WIDTH-1:0] cnt_d,
  input  logic [WIDTH-1:0] period_d,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             pol_in,
  output logic             pwm_out
);

  logic [WIDTH-1:0] duty_q;
  logic [WIDTH-1:0] duty_d;
  logic             pol_q;
  logic             pol_d;
  logic             pwm_q;
  logic             pwm_d;
  logic [WIDTH-1:0] duty_clamp;
  logic [WIDTH-1:0] center_thresh;
  logic             active;

  always_comb begin
    duty_d = load ? duty_in : duty_q;
    pol_d  = load ? pol_in  : pol_q;

    // A duty at or above the period means "always active"; clamping keeps the
    // center threshold below from underflowing.
    duty_clamp    = (duty_d > period_d) ? period_d : duty_d;
    center_thresh = period_d - duty_clamp;

    active = 1'b0;
    // A zero period has no counter range at all, so the channel stays
    // inactive (the center compare alone would otherwise be always true).
    if (!idle_d && (period_d != '0)) begin
      if (mode_d == PWM_EDGE) begin
        active = (cnt_d < duty_clamp);
      end else begin
        // Each counter value is visited once going up and once going down,
        // so the top Dc values give 2*Dc highs centred on the turn-around.
        active = (cnt_d >= center_thresh);
      end
    end

    pwm_d = active ^ pol_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
      pol_q  <= 1'b0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pol_q  <= pol_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_multi_channel.sv
// -----------------------------------------------------------------------------
// pwm_multi_channel
// N-channel PWM generator built around one shared period counter. Supports
// edge-aligned and center-aligned operation and per-channel duty/polarity.
// Period, mode, duty and polarity are held in active (shadow) registers that
// only update while idle or on the edge that starts a new period, so changes
// written mid-period never produce a truncated or glitched pulse.
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   enable   in   1 = run, 0 = idle (outputs at inactive level)
//   mode     in   0 = edge-aligned, 1 = center-aligned
//   period   in   period length P in counter steps
//   duty     in   channel i duty at [i*WIDTH +: WIDTH]
//   pol      in   per-channel output inversion
//   pwm_out  out  registered PWM outputs
//   tick     out  registered 1-cycle pulse in the first cycle of each period
// -----------------------------------------------------------------------------
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_DEFAULT_WIDTH,
  parameter int N     = PWM_DEFAULT_N
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               mode,
  input  logic [WIDTH-1:0]   period,
  input  logic [N*WIDTH-1:0] duty,
  input  logic [N-1:0]       pol,
  output logic [N-1:0]       pwm_out,
  output logic               tick
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  pwm_state_e       state_q;
  pwm_state_e       state_d;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             tick_q;
  logic             tick_d;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] period_d;
  pwm_mode_e        mode_q;
  pwm_mode_e        mode_d;

  logic             load;
  logic             at_top;
  logic             wrap_up;
  logic             idle_d;

  // ---------------------------------------------------------------------------
  // Counter FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    load    = 1'b0;

    // Periods of 0 or 1 have no room to count, so they are always at the top.
    // The >= (rather than ==) keeps the counter bounded even if it were ever
    // above the period.
    at_top  = (period_q <= CNT_ONE) || (cnt_q >= (period_q - CNT_ONE));

    // A zero period has no down-slope either; treat it like an edge-mode
    // period so it still ticks every cycle.
    wrap_up = (mode_q == PWM_EDGE) || (period_q == '0);

    unique case (state_q)
      PWM_IDLE: begin
        load = 1'b1;
        cnt_d = '0;
        if (enable) begin
          state_d = PWM_UP;
          tick_d  = 1'b1;
        end
      end

      PWM_UP: begin
        if (at_top) begin
          if (wrap_up) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            load   = 1'b1;
          end else begin
            // Hold the top value for one cycle so it is seen on the way down too.
            state_d = PWM_DOWN;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      PWM_DOWN: begin
        if (cnt_q == '0) begin
          state_d = PWM_UP;
          tick_d  = 1'b1;
          load    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = PWM_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Disable wins from any state; only an already-idle cycle keeps loading.
    if (!enable) begin
      state_d = PWM_IDLE;
      cnt_d   = '0;
      tick_d  = 1'b0;
      load    = (state_q == PWM_IDLE);
    end

    period_d = load ? period : period_q;
    mode_d   = load ? pwm_mode_e'(mode) : mode_q;
    idle_d   = (state_d == PWM_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PWM_IDLE;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      period_q <= '0;
      mode_q   <= PWM_EDGE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      period_q <= period_d;
      mode_q   <= mode_d;
    end
  end

  assign tick = tick_q;

  // ---------------------------------------------------------------------------
  // Per-channel compare
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      pwm_channel_cmp #(
        .WIDTH (WIDTH)
      ) u_cmp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .idle_d   (idle_d),
        .mode_d   (mode_d),
        .cnt_d    (cnt_d),
        .period_d (period_d),
        .duty_in  (duty[gi*WIDTH +: WIDTH]),
        .pol_in   (pol[gi]),
        .pwm_out  (pwm_out[gi])
      );
    end
  endgenerate

endmodule
